// File: rtl/fpro_bus_pkg.sv
// Shared types and widths for the FPro MMIO bus initiator.
package fpro_bus_pkg;

  localparam int unsigned MMIO_ADDR_W = 21;
  localparam int unsigned MMIO_DATA_W = 32;

  // One queued bus request as stored in the request FIFO
  typedef struct packed {
    logic                   wr;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] wr_data;
  } mmio_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } mmio_state_e;

endpackage

// File: rtl/mmio_req_fifo.sv
// Generic register-file FIFO with full/empty flags; head entry is visible combinationally.
module mmio_req_fifo #(
  parameter int unsigned FIFO_DEPTH_BIT = 2,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data_c,
  output logic              o_full_c,
  output logic              o_empty_c
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BIT;
  localparam int unsigned PTR_W = FIFO_DEPTH_BIT + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match
  assign o_empty_c   = (r_wr_ptr == r_rd_ptr);
  assign o_full_c    = (r_wr_ptr[FIFO_DEPTH_BIT] != r_rd_ptr[FIFO_DEPTH_BIT]) &&
                       (r_wr_ptr[FIFO_DEPTH_BIT-1:0] == r_rd_ptr[FIFO_DEPTH_BIT-1:0]);
  assign w_push      = i_push && !o_full_c;
  assign w_pop       = i_pop && !o_empty_c;
  assign o_rd_data_c = r_mem[r_rd_ptr[FIFO_DEPTH_BIT-1:0]];

  // Storage array; contents are don't-care while empty so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_DEPTH_BIT-1:0]] <= i_wr_data;
    end
  end

  // Read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fpro_mmio_initiator.sv
// Bus-master end of the FPro MMIO bus: queues client requests, issues one-cycle
// strobes, captures read data and returns it on a valid/ready response port.
module fpro_mmio_initiator
  import fpro_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_BIT = 2,
  parameter int unsigned ADDR_W         = MMIO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rd_data,
  output logic              busy,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [31:0]       mmio_wr_data,
  input  logic [31:0]       mmio_rd_data
);

  mmio_state_e       r_state;
  mmio_state_e       w_state_nxt;
  mmio_req_t         w_push_req;
  mmio_req_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_in_xfer;
  logic              w_head_issuable;
  logic              w_cs_nxt;
  logic              w_wr_nxt;
  logic              w_rd_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [31:0]       w_wdata_nxt;

  assign w_push_req.wr      = req_wr;
  assign w_push_req.addr    = MMIO_ADDR_W'(req_addr);
  assign w_push_req.wr_data = req_wr_data;

  // Full is sampled from the registered pointers, so a same-cycle pop never frees a slot early
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign busy      = !w_empty || (r_state == XFER);

  // A read may issue only when the response register will be free and no read is on the bus
  assign w_rd_in_xfer    = (r_state == XFER) && mmio_rd;
  assign w_head_issuable = w_head.wr || ((!rsp_valid || rsp_ready) && !w_rd_in_xfer);
  assign w_pop           = !w_empty && w_head_issuable;

  mmio_req_fifo #(
    .FIFO_DEPTH_BIT(FIFO_DEPTH_BIT),
    .DATA_W        ($bits(mmio_req_t))
  ) u_req_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_wr_data  (w_push_req),
    .i_pop      (w_pop),
    .o_rd_data_c(w_head),
    .o_full_c   (w_full),
    .o_empty_c  (w_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: stay in XFER while issuable requests keep arriving at the head
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = XFER;
      XFER:    w_state_nxt = w_pop ? XFER : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next bus outputs: strobes only for a popped entry, address/data hold when idle
  always_comb begin
    w_cs_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_addr_nxt  = mmio_addr;
    w_wdata_nxt = mmio_wr_data;
    if (w_pop) begin
      w_cs_nxt    = 1'b1;
      w_wr_nxt    = w_head.wr;
      w_rd_nxt    = !w_head.wr;
      w_addr_nxt  = ADDR_W'(w_head.addr);
      w_wdata_nxt = w_head.wr_data;
    end
  end

  // Registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
    end else begin
      mmio_cs      <= w_cs_nxt;
      mmio_wr      <= w_wr_nxt;
      mmio_rd      <= w_rd_nxt;
      mmio_addr    <= w_addr_nxt;
      mmio_wr_data <= w_wdata_nxt;
    end
  end

  // Response register: capture wins over a same-edge handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_rd_data <= '0;
    end else if (w_rd_in_xfer) begin
      rsp_valid   <= 1'b1;
      rsp_rd_data <= mmio_rd_data;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule
